// File: rtl/text_frame_pkg.sv
// Shared definitions for the text link framer/deframer pair.
package text_frame_pkg;

   typedef enum logic [1:0] {
      HUNT,
      LEN,
      PAYLOAD,
      CHK
   } state_t;

   localparam logic [1:0] ERR_NONE    = 2'd0;
   localparam logic [1:0] ERR_LEN_BAD = 2'd1;
   localparam logic [1:0] ERR_CHK_BAD = 2'd2;
   localparam logic [1:0] ERR_TIMEOUT = 2'd3;

   localparam logic [7:0] SOF_DEFAULT = 8'h7E;

endpackage

// File: rtl/frame_gap_timer.sv
// Mid-frame idle counter: fires once after TIMEOUT consecutive idle cycles.
module frame_gap_timer #(
   parameter int TIMEOUT = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic run,
   input  logic kick,
   output logic expired
);

   localparam int TW = $clog2(TIMEOUT + 1);

   logic [TW-1:0] cnt;

   // A byte arriving on the final idle cycle beats the abort.
   assign expired = run && !kick && (cnt == TW'(TIMEOUT - 1));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt <= '0;
      end else if (!run || kick || expired) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/text_deframer.sv
// Receive-side deframer: SOF, LEN, payload, XOR check byte.
// Optional DEFRAMER_STATS_EN adds saturating good/bad frame counters.
module text_deframer
   import text_frame_pkg::*;
#(
   parameter logic [7:0] SOF_BYTE = SOF_DEFAULT,
   parameter int         MAX_LEN  = 64,
   parameter int         TIMEOUT  = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       in_valid,
   input  logic [7:0] in_data,
   output logic       out_valid,
   output logic [7:0] out_data,
   output logic       out_last,
   output logic       frame_ok,
   output logic       frame_err,
   output logic [1:0] err_code,
   output logic       busy
`ifdef DEFRAMER_STATS_EN
   ,
   output logic [15:0] good_cnt,
   output logic [15:0] bad_cnt
`endif
);

   localparam int         CW        = $clog2(MAX_LEN + 1);
   localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

   state_t        state;
   logic [CW-1:0] remain;
   logic [7:0]    xsum;
   logic          expired;

   frame_gap_timer #(
      .TIMEOUT(TIMEOUT)
   ) u_gap (
      .clk    (clk),
      .reset  (reset),
      .run    (state != HUNT),
      .kick   (in_valid),
      .expired(expired)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= HUNT;
         remain    <= '0;
         xsum      <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_last  <= 1'b0;
         frame_ok  <= 1'b0;
         frame_err <= 1'b0;
         err_code  <= ERR_NONE;
         busy      <= 1'b0;
      end else begin
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         frame_ok  <= 1'b0;
         frame_err <= 1'b0;
         if (in_valid) begin
            unique case (state)
               HUNT: begin
                  if (in_data == SOF_BYTE) begin
                     state <= LEN;
                     busy  <= 1'b1;
                  end
               end
               LEN: begin
                  if (in_data != 8'd0 && in_data <= MAX_LEN_B) begin
                     remain <= CW'(in_data);
                     xsum   <= in_data;
                     state  <= PAYLOAD;
                  end else begin
                     frame_err <= 1'b1;
                     err_code  <= ERR_LEN_BAD;
                     state     <= HUNT;
                     busy      <= 1'b0;
                  end
               end
               PAYLOAD: begin
                  out_valid <= 1'b1;
                  out_data  <= in_data;
                  xsum      <= xsum ^ in_data;
                  remain    <= remain - 1'b1;
                  if (remain == CW'(1)) begin
                     out_last <= 1'b1;
                     state    <= CHK;
                  end
               end
               CHK: begin
                  if (in_data == xsum) begin
                     frame_ok <= 1'b1;
                  end else begin
                     frame_err <= 1'b1;
                     err_code  <= ERR_CHK_BAD;
                  end
                  state <= HUNT;
                  busy  <= 1'b0;
               end
            endcase
         end else if (expired) begin
            frame_err <= 1'b1;
            err_code  <= ERR_TIMEOUT;
            state     <= HUNT;
            busy      <= 1'b0;
         end
      end
   end

`ifdef DEFRAMER_STATS_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         good_cnt <= '0;
         bad_cnt  <= '0;
      end else begin
         if (frame_ok && good_cnt != 16'hFFFF)
            good_cnt <= good_cnt + 1'b1;
         if (frame_err && bad_cnt != 16'hFFFF)
            bad_cnt <= bad_cnt + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_text_deframer.sv
// Directed-vector bench for text_deframer.
module tb_text_deframer;

   logic       clk;
   logic       reset;
   logic       in_valid;
   logic [7:0] in_data;
   logic       out_valid;
   logic [7:0] out_data;
   logic       out_last;
   logic       frame_ok;
   logic       frame_err;
   logic [1:0] err_code;
   logic       busy;
`ifdef DEFRAMER_STATS_EN
   logic [15:0] good_cnt;
   logic [15:0] bad_cnt;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   text_deframer dut (
      .clk      (clk),
      .reset    (reset),
      .in_valid (in_valid),
      .in_data  (in_data),
      .out_valid(out_valid),
      .out_data (out_data),
      .out_last (out_last),
      .frame_ok (frame_ok),
      .frame_err(frame_err),
      .err_code (err_code),
      .busy     (busy)
`ifdef DEFRAMER_STATS_EN
      ,
      .good_cnt (good_cnt),
      .bad_cnt  (bad_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive at negedge; return 1 time unit after the accepting edge.
   task automatic step(input logic v, input logic [7:0] d);
      @(negedge clk);
      in_valid = v;
      in_data  = d;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset    = 1'b0;
      in_valid = 1'b0;
      in_data  = 8'h00;
      repeat (2) @(posedge clk);
      #1;
      n_tests++;
      if ({out_valid, out_last, frame_ok, frame_err, busy,
           err_code, out_data} !== 15'd0) begin
         n_fail++;
         $display("FAIL reset: got %b %b %b %b %b ec=%0d d=%h want all 0",
                  out_valid, out_last, frame_ok, frame_err, busy,
                  err_code, out_data);
      end
      @(negedge clk);
      reset = 1'b1;
   endtask

   // flags = {out_valid, out_last, frame_ok, frame_err, busy}
   task automatic test_good();
      logic [7:0] b  [6] = '{8'h7E, 8'h03, 8'h48, 8'h69, 8'h21, 8'h03};
      logic [4:0] fl [6] = '{5'b00001, 5'b00001, 5'b10001,
                             5'b10001, 5'b11001, 5'b00100};
      for (int i = 0; i < 6; i++) begin
         step(1'b1, b[i]);
         n_tests++;
         if ({out_valid, out_last, frame_ok, frame_err, busy} !== fl[i] ||
             (fl[i][4] && out_data !== b[i]) || err_code !== 2'd0) begin
            n_fail++;
            $display("FAIL good[%0d]: flags=%b d=%h ec=%0d want %b %h 0",
                     i, {out_valid, out_last, frame_ok, frame_err, busy},
                     out_data, err_code, fl[i], b[i]);
         end
      end
   endtask

   task automatic test_bad_chk();
      logic [7:0] b  [6] = '{8'h7E, 8'h03, 8'h48, 8'h69, 8'h21, 8'h04};
      logic [4:0] fl [6] = '{5'b00001, 5'b00001, 5'b10001,
                             5'b10001, 5'b11001, 5'b00010};
      logic [1:0] ec [6] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd2};
      for (int i = 0; i < 6; i++) begin
         step(1'b1, b[i]);
         n_tests++;
         if ({out_valid, out_last, frame_ok, frame_err, busy} !== fl[i] ||
             (fl[i][4] && out_data !== b[i]) || err_code !== ec[i]) begin
            n_fail++;
            $display("FAIL bad_chk[%0d]: flags=%b d=%h ec=%0d want %b %h %0d",
                     i, {out_valid, out_last, frame_ok, frame_err, busy},
                     out_data, err_code, fl[i], b[i], ec[i]);
         end
      end
   endtask

   task automatic test_bad_len();
      logic [7:0] b  [8] = '{8'h7E, 8'h00, 8'h7E, 8'h41,
                             8'h7E, 8'h01, 8'h5A, 8'h5B};
      logic [4:0] fl [8] = '{5'b00001, 5'b00010, 5'b00001, 5'b00010,
                             5'b00001, 5'b00001, 5'b11001, 5'b00100};
      logic [1:0] ec [8] = '{2'd2, 2'd1, 2'd1, 2'd1,
                             2'd1, 2'd1, 2'd1, 2'd1};
      for (int i = 0; i < 8; i++) begin
         step(1'b1, b[i]);
         n_tests++;
         if ({out_valid, out_last, frame_ok, frame_err, busy} !== fl[i] ||
             (fl[i][4] && out_data !== b[i]) || err_code !== ec[i]) begin
            n_fail++;
            $display("FAIL bad_len[%0d]: flags=%b d=%h ec=%0d want %b %h %0d",
                     i, {out_valid, out_last, frame_ok, frame_err, busy},
                     out_data, err_code, fl[i], b[i], ec[i]);
         end
      end
   endtask

   task automatic test_hunt();
      logic [7:0] b  [7] = '{8'h00, 8'h41, 8'hFF, 8'h7E,
                             8'h01, 8'h33, 8'h32};
      logic [4:0] fl [7] = '{5'b00000, 5'b00000, 5'b00000, 5'b00001,
                             5'b00001, 5'b11001, 5'b00100};
      for (int i = 0; i < 7; i++) begin
         step(1'b1, b[i]);
         n_tests++;
         if ({out_valid, out_last, frame_ok, frame_err, busy} !== fl[i] ||
             (fl[i][4] && out_data !== b[i]) || err_code !== 2'd1) begin
            n_fail++;
            $display("FAIL hunt[%0d]: flags=%b d=%h ec=%0d want %b %h 1",
                     i, {out_valid, out_last, frame_ok, frame_err, busy},
                     out_data, err_code, fl[i], b[i]);
         end
      end
   endtask

   task automatic test_timeout();
      logic [4:0] want;
      step(1'b1, 8'h7E);
      step(1'b1, 8'h04);
      step(1'b1, 8'h61);
      step(1'b1, 8'h62);
      n_tests++;
      if (out_valid !== 1'b1 || out_data !== 8'h62 || out_last !== 1'b0) begin
         n_fail++;
         $display("FAIL to_pay: v=%b d=%h l=%b want 1 62 0",
                  out_valid, out_data, out_last);
      end
      for (int k = 1; k <= 16; k++) begin
         step(1'b0, 8'h00);
         want = (k == 16) ? 5'b00010 : 5'b00001;
         n_tests++;
         if ({out_valid, out_last, frame_ok, frame_err, busy} !== want) begin
            n_fail++;
            $display("FAIL to_idle[%0d]: flags=%b want %b", k,
                     {out_valid, out_last, frame_ok, frame_err, busy}, want);
         end
      end
      n_tests++;
      if (err_code !== 2'd3) begin
         n_fail++;
         $display("FAIL to_code: ec=%0d want 3", err_code);
      end
      step(1'b0, 8'h00);
      n_tests++;
      if (frame_err !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL to_pulse: err=%b busy=%b want 0 0", frame_err, busy);
      end
      // Second pass: a byte on the 16th idle cycle keeps the frame alive.
      step(1'b1, 8'h7E);
      step(1'b1, 8'h04);
      step(1'b1, 8'h61);
      step(1'b1, 8'h62);
      for (int k = 1; k <= 15; k++) step(1'b0, 8'h00);
      n_tests++;
      if (busy !== 1'b1 || frame_err !== 1'b0) begin
         n_fail++;
         $display("FAIL to_15: busy=%b err=%b want 1 0", busy, frame_err);
      end
      step(1'b1, 8'h63);
      n_tests++;
      if ({out_valid, out_last, frame_ok, frame_err, busy} !== 5'b10001 ||
          out_data !== 8'h63) begin
         n_fail++;
         $display("FAIL to_save: flags=%b d=%h want 10001 63",
                  {out_valid, out_last, frame_ok, frame_err, busy}, out_data);
      end
      step(1'b1, 8'h64);
      n_tests++;
      if ({out_valid, out_last} !== 2'b11 || out_data !== 8'h64) begin
         n_fail++;
         $display("FAIL to_last: v=%b l=%b d=%h want 1 1 64",
                  out_valid, out_last, out_data);
      end
      step(1'b1, 8'h00);
      n_tests++;
      if ({frame_ok, frame_err, busy} !== 3'b100 || err_code !== 2'd3) begin
         n_fail++;
         $display("FAIL to_ok: ok=%b err=%b busy=%b ec=%0d want 1 0 0 3",
                  frame_ok, frame_err, busy, err_code);
      end
   endtask

   task automatic test_reset_mid();
      logic [7:0] b  [6] = '{8'h7E, 8'h03, 8'h48, 8'h69, 8'h21, 8'h03};
      logic [4:0] fl [6] = '{5'b00001, 5'b00001, 5'b10001,
                             5'b10001, 5'b11001, 5'b00100};
      step(1'b1, 8'h7E);
      step(1'b1, 8'h05);
      step(1'b1, 8'h41);
      reset = 1'b0;
      #1;
      n_tests++;
      if ({out_valid, out_last, frame_ok, frame_err, busy,
           err_code, out_data} !== 15'd0) begin
         n_fail++;
         $display("FAIL rst_mid: v=%b l=%b ok=%b err=%b busy=%b ec=%0d d=%h want 0",
                  out_valid, out_last, frame_ok, frame_err, busy,
                  err_code, out_data);
      end
`ifdef DEFRAMER_STATS_EN
      n_tests++;
      if (good_cnt !== 16'd0 || bad_cnt !== 16'd0) begin
         n_fail++;
         $display("FAIL rst_stats: good=%0d bad=%0d want 0 0",
                  good_cnt, bad_cnt);
      end
`endif
      @(negedge clk);
      in_valid = 1'b0;
      reset    = 1'b1;
      for (int i = 0; i < 6; i++) begin
         step(1'b1, b[i]);
         n_tests++;
         if ({out_valid, out_last, frame_ok, frame_err, busy} !== fl[i] ||
             (fl[i][4] && out_data !== b[i]) || err_code !== 2'd0) begin
            n_fail++;
            $display("FAIL post_rst[%0d]: flags=%b d=%h ec=%0d want %b %h 0",
                     i, {out_valid, out_last, frame_ok, frame_err, busy},
                     out_data, err_code, fl[i], b[i]);
         end
      end
      step(1'b0, 8'h00);
`ifdef DEFRAMER_STATS_EN
      n_tests++;
      if (good_cnt !== 16'd1 || bad_cnt !== 16'd0) begin
         n_fail++;
         $display("FAIL post_stats: good=%0d bad=%0d want 1 0",
                  good_cnt, bad_cnt);
      end
`endif
   endtask

   initial begin
      test_reset();
      test_good();
      test_bad_chk();
      test_bad_len();
      test_hunt();
      test_timeout();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
